// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared widths, signed-magnitude type and helpers for the MLP datapath
package mlp_pkg;

  localparam int W     = 32;
  localparam int FRAC  = 17;
  localparam int N     = 32;
  localparam int IDX_W = $clog2(N);

  typedef struct packed {
    logic         sign;
    logic [W-2:0] mag;
  } sm32_t;

  localparam logic [W-1:0] SM_MAX = 32'h7FFFFFFF;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic sm_sign(input logic [W-1:0] v);
    return v[W-1];
  endfunction

  function automatic logic [W-2:0] sm_mag(input logic [W-1:0] v);
    return v[W-2:0];
  endfunction

endpackage

// File: rtl/sm_mul32.sv
// rtl/sm_mul32.sv - combinational signed-magnitude Q14.17 multiply, truncating and saturating
module sm_mul32
  import mlp_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] prod,
  output logic         ovf
);

  localparam int PW = 2 * (W - 1);

  logic [PW-1:0] full;
  logic [PW-1:0] shifted;
  logic [W-2:0]  mag;
  sm32_t         res;

  // Full-width magnitude product, drop FRAC bits, clamp anything that no longer fits,
  // and never emit a negative zero.
  always_comb begin
    full     = PW'(sm_mag(a)) * PW'(sm_mag(b));
    shifted  = full >> FRAC;
    ovf      = |shifted[PW-1:W-1];
    mag      = ovf ? SM_MAX[W-2:0] : shifted[W-2:0];
    res.mag  = mag;
    res.sign = (sm_sign(a) ^ sm_sign(b)) & (|mag);
    prod     = res;
  end

endmodule

// File: rtl/mac_prod32.sv
// rtl/mac_prod32.sv - collects N streamed x*w products into a frame handed to sigma32
module mac_prod32
  import mlp_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] w,
  input  logic         clear,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] p [0:N-1],
  output logic         sat
);

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  idx;
  logic [W-1:0]      prod;
  logic              ovf;
  logic              accept;
  logic              last;

  sm_mul32 u_mul (
    .a    (x),
    .b    (w),
    .prod (prod),
    .ovf  (ovf)
  );

  // Handshake outputs and next state; a pair arriving with clear is dropped.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    last       = (idx == IDX_W'(N - 1));
    case (state)
      FILL: begin
        in_ready = 1'b1;
        accept   = in_valid & ~clear;
        if (accept && last) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Write index and sticky saturation flag; both restart on clear or on frame handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      sat <= 1'b0;
    end else if (state == FILL) begin
      if (clear) begin
        idx <= '0;
        sat <= 1'b0;
      end else if (accept) begin
        idx <= last ? '0 : idx + IDX_W'(1);
        sat <= sat | ovf;
      end
    end else if (out_ready) begin
      sat <= 1'b0;
    end
  end

  // Product buffer, written in acceptance order; frozen while the frame is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        p[i] <= '0;
      end
    end else if (accept) begin
      p[idx] <= prod;
    end
  end

endmodule

// File: tb/tb_mac_prod32.sv
// tb/tb_mac_prod32.sv - self-checking bench for mac_prod32
module tb_mac_prod32;

  localparam int NP = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] w;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p [0:NP-1];
  logic        sat;

  int total = 0;
  int bad   = 0;

  logic [31:0] sb [$];

  typedef struct {
    string       name;
    logic [31:0] xv;
    logic [31:0] wv;
    logic [31:0] exp_p;
    logic        exp_sat;
  } vec_t;

  vec_t tbl [$];

  mac_prod32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .w         (w),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] xv, input logic [31:0] wv, input logic [31:0] ex);
    int n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) begin
      chk("send_wait_in_ready", {31'b0, in_ready}, 32'd1);
    end else begin
      in_valid = 1'b1;
      x        = xv;
      w        = wv;
      sb.push_back(ex);
      step();
      in_valid = 1'b0;
    end
  endtask

  task automatic check_frame(input string name, input logic exp_sat);
    chk({name, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < NP; i++) begin
      if (sb.size() == 0) begin
        chk({name, "_sb_underflow"}, 32'd0, 32'd1);
      end else begin
        chk($sformatf("%s_p%0d", name, i), p[i], sb.pop_front());
      end
    end
    chk({name, "_sat"}, {31'b0, sat}, {31'b0, exp_sat});
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, "_consume_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({name, "_consume_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({name, "_consume_sat"}, {31'b0, sat}, 32'd0);
  endtask

  task automatic check_reset_state(input string name);
    int nz = 0;
    for (int i = 0; i < NP; i++) begin
      if (p[i] !== 32'h0) nz++;
    end
    chk({name, "_p_zero_count"}, nz, 32'd0);
    chk({name, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({name, "_sat"}, {31'b0, sat}, 32'd0);
  endtask

  initial begin
    logic [31:0] held [0:NP-1];
    int          nbad;

    tbl.push_back('{"unit",       32'h0006487e, 32'h00020000, 32'h0006487e, 1'b0});
    tbl.push_back('{"neg",        32'h0006487e, 32'h80020000, 32'h8006487e, 1'b0});
    tbl.push_back('{"negneg",     32'h8006487e, 32'h80020000, 32'h0006487e, 1'b0});
    tbl.push_back('{"zero_sign",  32'h00000000, 32'h80030000, 32'h00000000, 1'b0});
    tbl.push_back('{"half_two",   32'h00010000, 32'h00040000, 32'h00020000, 1'b0});
    tbl.push_back('{"sq_1p5",     32'h00030000, 32'h00030000, 32'h00048000, 1'b0});
    tbl.push_back('{"trunc",      32'h00000003, 32'h00010000, 32'h00000001, 1'b0});
    tbl.push_back('{"tiny_neg0",  32'h80000001, 32'h00000001, 32'h00000000, 1'b0});
    tbl.push_back('{"just_below", 32'h3FFFFFFF, 32'h00040000, 32'h7FFFFFFE, 1'b0});
    tbl.push_back('{"just_over",  32'h40000000, 32'h00040000, 32'h7FFFFFFF, 1'b1});
    tbl.push_back('{"sat_neg",    32'hC0000000, 32'h00040000, 32'hFFFFFFFF, 1'b1});
    tbl.push_back('{"sat_max",    32'h7FFFFFFF, 32'h00040000, 32'h7FFFFFFF, 1'b1});

    rst       = 1'b1;
    in_valid  = 1'b0;
    x         = '0;
    w         = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_reset_state("reset");

    // Whole frames of one repeated pair, checking the rise of out_valid on the last accept.
    foreach (tbl[k]) begin
      for (int i = 0; i < NP - 1; i++) send(tbl[k].xv, tbl[k].wv, tbl[k].exp_p);
      chk({tbl[k].name, "_not_yet_valid"}, {31'b0, out_valid}, 32'd0);
      send(tbl[k].xv, tbl[k].wv, tbl[k].exp_p);
      check_frame(tbl[k].name, tbl[k].exp_sat);
      consume(tbl[k].name);
    end

    // Single saturating pair at index 5; clear during HOLD must be ignored.
    for (int i = 0; i < NP; i++) begin
      if (i == 5) send(32'h7FFFFFFF, 32'h00040000, 32'h7FFFFFFF);
      else        send(32'h00020000, 32'h00020000, 32'h00020000);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("hold_clear_out_valid", {31'b0, out_valid}, 32'd1);
    check_frame("sat5", 1'b1);
    consume("sat5");

    // Backpressure: distinct products, then 20 held cycles with a pair knocking.
    for (int i = 0; i < NP; i++) begin
      held[i] = 32'(i + 1) << 17;
      send(held[i], 32'h00020000, held[i]);
    end
    sb.delete();
    in_valid = 1'b1;
    x        = 32'h00050000;
    w        = 32'h00020000;
    for (int c = 0; c < 20; c++) begin
      step();
      nbad = 0;
      for (int i = 0; i < NP; i++) if (p[i] !== held[i]) nbad++;
      chk($sformatf("bp_c%0d_in_ready", c), {31'b0, in_ready}, 32'd0);
      chk($sformatf("bp_c%0d_p_changed", c), nbad, 32'd0);
      chk($sformatf("bp_c%0d_out_valid", c), {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    consume("bp");
    send(32'h00070000, 32'h80020000, 32'h80070000);
    chk("bp_next_p0", p[0], 32'h80070000);
    chk("bp_next_p1_kept", p[1], held[1]);
    for (int i = 1; i < NP; i++) send(32'h00010000, 32'h00020000, 32'h00010000);
    check_frame("bp_next", 1'b0);
    consume("bp_next");

    // Clear mid-frame; the pair presented with clear is dropped.
    for (int i = 0; i < 10; i++) begin
      if (i == 3) send(32'h7FFFFFFF, 32'h00040000, 32'h7FFFFFFF);
      else        send(32'h00030000, 32'h00020000, 32'h00030000);
    end
    chk("clr_sat_before", {31'b0, sat}, 32'd1);
    in_valid = 1'b1;
    x        = 32'h7FFFFFFF;
    w        = 32'h00040000;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("clr_sat_after", {31'b0, sat}, 32'd0);
    for (int i = 0; i < NP - 1; i++) send(32'h00010000, 32'h00040000, 32'h00020000);
    chk("clr_not_yet_valid", {31'b0, out_valid}, 32'd0);
    send(32'h00010000, 32'h00040000, 32'h00020000);
    check_frame("clr", 1'b0);
    consume("clr");

    // Reset mid-frame, with a pair presented during reset.
    for (int i = 0; i < 10; i++) begin
      if (i == 2) send(32'h7FFFFFFF, 32'h00040000, 32'h7FFFFFFF);
      else        send(32'h00030000, 32'h00020000, 32'h00030000);
    end
    in_valid = 1'b1;
    x        = 32'h00030000;
    w        = 32'h00020000;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check_reset_state("midrst");
    for (int i = 0; i < NP - 1; i++) send(32'h00010000, 32'h00040000, 32'h00020000);
    chk("midrst_not_yet_valid", {31'b0, out_valid}, 32'd0);
    send(32'h00010000, 32'h00040000, 32'h00020000);
    check_frame("midrst", 1'b0);
    consume("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
